alu_seq_shift: RTL

Parametrised sequential successor of the team's 5-bit NOT/shift ALU. It takes operands through a valid/ready handshake and computes bitwise NOT, logical shifts and an optional rotate. Shifts are iterative, one bit position per clock, so no barrel shifter is needed. The result and CF/SF/ZF are registered and held until the next completion; the block sits between the operand register stage and the flag/result writeback stage.

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_shift_step.sv | 36 +++
 rtl/alu_seq_shift.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state encoding for the sequential NOT/shift/rotate ALU.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ALU_OP_NOT = 2'b00,
    ALU_OP_SHL = 2'b01,
    ALU_OP_SHR = 2'b10,
    ALU_OP_ROL = 2'b11
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-position shift/rotate step with the bit moved out as carry.
// The rotate path is only built when ALU_SEQ_ROTATE_EN is defined.
module alu_shift_step
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] work,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] work_next,
  output logic             carry
);

  always_comb begin
    work_next = work;
    carry     = 1'b0;
    case (op)
      ALU_OP_SHL: begin
        carry     = work[WIDTH-1];
        work_next = {work[WIDTH-2:0], 1'b0};
      end
      ALU_OP_SHR: begin
        carry     = work[0];
        work_next = {1'b0, work[WIDTH-1:1]};
      end
`ifdef ALU_SEQ_ROTATE_EN
      ALU_OP_ROL: begin
        carry     = work[WIDTH-1];
        work_next = {work[WIDTH-2:0], work[WIDTH-1]};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_shift.sv
// Sequential NOT / logical shift / rotate ALU, one bit position per clock.
// Define ALU_SEQ_ROTATE_EN to enable ROL; otherwise op 11 completes at once with r=0.
module alu_seq_shift
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cf,
  output logic             sf,
  output logic             zf
);

  localparam logic [WIDTH-1:0] WIDTH_CNT = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_CNT   = WIDTH'(1);

  alu_state_e       state;
  alu_op_e          op_q;
  alu_op_e          op_in;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] imm_r;
  logic             imm;
  logic             accept;
  logic [WIDTH-1:0] step_work;
  logic             step_carry;

  function automatic logic sign_of(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction

  function automatic logic zero_of(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign op_in    = alu_op_e'(op);

  // Step count and the immediate-completion decision for the op being offered.
  always_comb begin
    n     = '0;
    imm   = 1'b1;
    imm_r = a;
    case (op_in)
      ALU_OP_NOT: begin
        imm_r = ~a;
      end
      ALU_OP_SHL, ALU_OP_SHR: begin
        n   = (b < WIDTH_CNT) ? b : WIDTH_CNT;
        imm = (b == '0);
      end
      ALU_OP_ROL: begin
`ifdef ALU_SEQ_ROTATE_EN
        n   = b;
        imm = (b == '0);
`else
        imm_r = '0;
`endif
      end
      default: ;
    endcase
  end

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .work      (work),
    .op        (op_q),
    .work_next (step_work),
    .carry     (step_carry)
  );

  // Working register is pure data: loaded with the operand while idle, stepped while shifting.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) work <= a;
    else                  work <= step_work;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= ALU_OP_NOT;
      cnt   <= '0;
      done  <= 1'b0;
      r     <= '0;
      cf    <= 1'b0;
      sf    <= 1'b0;
      zf    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op_in;
            cnt  <= n;
            if (imm) begin
              done <= 1'b1;
              r    <= imm_r;
              cf   <= 1'b0;
              sf   <= sign_of(imm_r);
              zf   <= zero_of(imm_r);
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          cnt <= cnt - ONE_CNT;
          // Final step writes the stepped value straight into the result.
          if (cnt == ONE_CNT) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            r     <= step_work;
            cf    <= step_carry;
            sf    <= sign_of(step_work);
            zf    <= zero_of(step_work);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
